uart_rx: RTL and testbench

- Serial receiver for the SoC UART. It is the receive end of the link whose transmit side drives oUART_TX.
- Samples the top-level iUART_RX pin and deframes 8N1 characters (1 start, 8 data LSB-first, 1 stop, no parity).
- Presents each byte to the memory-mapped UART register logic through a one-entry holding register with a valid/read handshake.
- Sticky framing-error and overrun flags report line and software faults.

---
 rtl/uart_rx_if.sv | 20 ++
 rtl/uart_rx.sv | 139 +++++++++++++
 tb/tb_uart_rx.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - holding-register handshake and status bundle for uart_rx
interface uart_rx_if;
    logic [7:0] oRXDATA;
    logic       oRXVALID;
    logic       iRXREAD;
    logic       oFRAMEERR;
    logic       oOVERRUN;
    logic       iERRCLR;
    logic       oBUSY;

    modport master (
        output oRXDATA, oRXVALID, oFRAMEERR, oOVERRUN, oBUSY,
        input  iRXREAD, iERRCLR
    );

    modport slave (
        input  oRXDATA, oRXVALID, oFRAMEERR, oOVERRUN, oBUSY,
        output iRXREAD, iERRCLR
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with one-entry holding register and sticky error flags
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic      iCLK,
    input  logic      iRST,
    input  logic      iUART_RX,
    uart_rx_if.master rxIf
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t        state, nState;
    logic [CW-1:0] cnt, nCnt;
    logic [2:0]    bitIdx, nBitIdx;
    logic [7:0]    shiftReg, nShiftReg;
    logic          rxMeta, rxs;
    logic [7:0]    rxData;
    logic          rxValid, frameErr, overrun;
    logic          loadByte, setFrameErr;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            rxMeta <= 1'b1;
            rxs    <= 1'b1;
        end else begin
            rxMeta <= iUART_RX;
            rxs    <= rxMeta;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state    <= IDLE;
            cnt      <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
        end else begin
            state    <= nState;
            cnt      <= nCnt;
            bitIdx   <= nBitIdx;
            shiftReg <= nShiftReg;
        end
    end

    always_comb begin
        nState      = state;
        nCnt        = cnt;
        nBitIdx     = bitIdx;
        nShiftReg   = shiftReg;
        loadByte    = 1'b0;
        setFrameErr = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rxs) begin
                    nState = START;
                    nCnt   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    nCnt    = '0;
                    nBitIdx = '0;
                    nState  = rxs ? IDLE : DATA;
                end else begin
                    nCnt = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    nCnt      = '0;
                    nShiftReg = {rxs, shiftReg[7:1]};
                    if (bitIdx == 3'd7) begin
                        nState = STOP;
                    end else begin
                        nBitIdx = bitIdx + 3'd1;
                    end
                end else begin
                    nCnt = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    nCnt = '0;
                    if (rxs) begin
                        loadByte = 1'b1;
                        nState   = IDLE;
                    end else begin
                        setFrameErr = 1'b1;
                        nState      = WAIT_IDLE;
                    end
                end else begin
                    nCnt = cnt + CW'(1);
                end
            end
            WAIT_IDLE: begin
                if (rxs) begin
                    nState = IDLE;
                end
            end
            default: nState = IDLE;
        endcase
    end

    // A load beats a simultaneous read, and a flag set beats a simultaneous clear
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            rxData   <= '0;
            rxValid  <= 1'b0;
            frameErr <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (loadByte) begin
                rxData  <= shiftReg;
                rxValid <= 1'b1;
            end else if (rxIf.iRXREAD) begin
                rxValid <= 1'b0;
            end
            frameErr <= setFrameErr | (frameErr & ~rxIf.iERRCLR);
            overrun  <= (loadByte & rxValid & ~rxIf.iRXREAD) | (overrun & ~rxIf.iERRCLR);
        end
    end

    assign rxIf.oRXDATA   = rxData;
    assign rxIf.oRXVALID  = rxValid;
    assign rxIf.oFRAMEERR = frameErr;
    assign rxIf.oOVERRUN  = overrun;
    assign rxIf.oBUSY     = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx against a frame-level holding-register model
module tb_uart_rx;
    localparam int CPB = 16;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    logic iUART_RX = 1'b1;
    uart_rx_if rxIf ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iUART_RX(iUART_RX),
        .rxIf    (rxIf.master)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;
    int loadCyc = 154;

    logic [7:0] mData;
    logic       mValid, mFrameErr, mOverrun;

    task automatic modelReset();
        mData = 8'h00; mValid = 1'b0; mFrameErr = 1'b0; mOverrun = 1'b0;
    endtask

    task automatic modelFrame(input logic [7:0] d, input logic stopBit, input logic readInLoad);
        if (stopBit) begin
            if (mValid && !readInLoad) mOverrun = 1'b1;
            mData  = d;
            mValid = 1'b1;
        end else begin
            mFrameErr = 1'b1;
        end
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic stopBit, input int readCyc,
                             output int rise, output logic [7:0] cap);
        logic [9:0] bits;
        logic       prevV;
        bits  = {stopBit, d, 1'b0};
        rise  = -1;
        cap   = 8'h00;
        prevV = rxIf.oRXVALID;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge iCLK);
                if (rise < 0 && rxIf.oRXVALID && !prevV) begin
                    rise = i * CPB + c;
                    cap  = rxIf.oRXDATA;
                end
                prevV        = rxIf.oRXVALID;
                rxIf.iRXREAD = (i * CPB + c == readCyc);
                iUART_RX     = bits[i];
            end
        end
        @(negedge iCLK);
        rxIf.iRXREAD = 1'b0;
    endtask

    task automatic readByte();
        @(negedge iCLK); rxIf.iRXREAD = 1'b1;
        @(negedge iCLK); rxIf.iRXREAD = 1'b0;
        mValid = 1'b0;
    endtask

    task automatic errClear();
        @(negedge iCLK); rxIf.iERRCLR = 1'b1;
        @(negedge iCLK); rxIf.iERRCLR = 1'b0;
        mFrameErr = 1'b0; mOverrun = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge iCLK);
    endtask

    task automatic test_reset();
        int r; logic [7:0] cap;
        sendFrame(8'($urandom), 1'b1, -1, r, cap);
        sendFrame(8'($urandom), 1'b1, -1, r, cap);
        @(negedge iCLK); iUART_RX = 1'b0;
        idleCycles(20);
        #2 iRST = 1'b1;
        #1;
        modelReset();
        checks++;
        if (rxIf.oRXDATA !== mData || rxIf.oRXVALID !== mValid || rxIf.oFRAMEERR !== mFrameErr ||
            rxIf.oOVERRUN !== mOverrun || rxIf.oBUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: data=%h valid=%b fe=%b ov=%b busy=%b, want all zero",
                     rxIf.oRXDATA, rxIf.oRXVALID, rxIf.oFRAMEERR, rxIf.oOVERRUN, rxIf.oBUSY);
        end
        iUART_RX = 1'b1;
        idleCycles(3);
        iRST = 1'b0;
        idleCycles(5);
    endtask

    task automatic test_single_byte();
        int r; logic [7:0] cap, d;
        for (int k = 0; k < 5; k++) begin
            d = (k == 0) ? 8'hA5 : 8'($urandom);
            sendFrame(d, 1'b1, -1, r, cap);
            modelFrame(d, 1'b1, 1'b0);
            checks++;
            if (cap !== mData || rxIf.oRXDATA !== mData || rxIf.oRXVALID !== 1'b1) begin
                errors++;
                $display("FAIL single_data[%0d]: got %h valid=%b, want %h valid=1", k, cap, rxIf.oRXVALID, mData);
            end
            checks++;
            if (r < 152 || r > 158) begin
                errors++;
                $display("FAIL single_latency[%0d]: valid rose at cycle %0d, want 152..158", k, r);
            end
            if (k == 0 && r >= 152) loadCyc = r - 1;
            idleCycles(3);
            checks++;
            if (rxIf.oRXVALID !== 1'b1) begin
                errors++;
                $display("FAIL single_hold[%0d]: valid=%b, want 1", k, rxIf.oRXVALID);
            end
            readByte();
            checks++;
            if (rxIf.oRXVALID !== mValid || rxIf.oFRAMEERR !== mFrameErr || rxIf.oOVERRUN !== mOverrun) begin
                errors++;
                $display("FAIL single_read[%0d]: valid=%b fe=%b ov=%b, want 0 0 0",
                         k, rxIf.oRXVALID, rxIf.oFRAMEERR, rxIf.oOVERRUN);
            end
            idleCycles($urandom_range(0, 20));
        end
    endtask

    task automatic test_glitch();
        logic sawBusy;
        sawBusy = 1'b0;
        @(negedge iCLK); iUART_RX = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge iCLK);
            if (rxIf.oBUSY) sawBusy = 1'b1;
        end
        iUART_RX = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge iCLK);
            if (rxIf.oBUSY) sawBusy = 1'b1;
        end
        checks++;
        if (sawBusy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_pulse: busy seen=%b, want 1", sawBusy);
        end
        checks++;
        if (rxIf.oBUSY !== 1'b0 || rxIf.oRXVALID !== mValid || rxIf.oFRAMEERR !== mFrameErr) begin
            errors++;
            $display("FAIL glitch_reject: busy=%b valid=%b fe=%b, want 0 0 0",
                     rxIf.oBUSY, rxIf.oRXVALID, rxIf.oFRAMEERR);
        end
    endtask

    task automatic test_framing_error();
        int r, w; logic [7:0] cap;
        sendFrame(8'h3C, 1'b0, -1, r, cap);
        modelFrame(8'h3C, 1'b0, 1'b0);
        idleCycles(40);
        checks++;
        if (rxIf.oFRAMEERR !== mFrameErr || rxIf.oRXVALID !== mValid || rxIf.oBUSY !== 1'b1) begin
            errors++;
            $display("FAIL frame_err: fe=%b valid=%b busy=%b, want 1 0 1",
                     rxIf.oFRAMEERR, rxIf.oRXVALID, rxIf.oBUSY);
        end
        iUART_RX = 1'b1;
        w = 0;
        while (rxIf.oBUSY && w < 10) begin
            @(negedge iCLK);
            w++;
        end
        checks++;
        if (rxIf.oBUSY !== 1'b0) begin
            errors++;
            $display("FAIL frame_release: busy=%b after %0d cycles, want 0", rxIf.oBUSY, w);
        end
        sendFrame(8'h55, 1'b1, -1, r, cap);
        modelFrame(8'h55, 1'b1, 1'b0);
        checks++;
        if (rxIf.oRXDATA !== mData || rxIf.oRXVALID !== mValid || rxIf.oFRAMEERR !== mFrameErr) begin
            errors++;
            $display("FAIL frame_recover: data=%h valid=%b fe=%b, want %h 1 1",
                     rxIf.oRXDATA, rxIf.oRXVALID, rxIf.oFRAMEERR, mData);
        end
        readByte();
        errClear();
        checks++;
        if (rxIf.oFRAMEERR !== 1'b0 || rxIf.oRXVALID !== 1'b0) begin
            errors++;
            $display("FAIL frame_clear: fe=%b valid=%b, want 0 0", rxIf.oFRAMEERR, rxIf.oRXVALID);
        end
    endtask

    task automatic test_overrun();
        int r; logic [7:0] cap;
        sendFrame(8'h11, 1'b1, -1, r, cap);
        modelFrame(8'h11, 1'b1, 1'b0);
        sendFrame(8'h22, 1'b1, -1, r, cap);
        modelFrame(8'h22, 1'b1, 1'b0);
        checks++;
        if (rxIf.oRXDATA !== mData || rxIf.oOVERRUN !== mOverrun || rxIf.oRXVALID !== mValid) begin
            errors++;
            $display("FAIL overrun_set: data=%h ov=%b valid=%b, want %h %b %b",
                     rxIf.oRXDATA, rxIf.oOVERRUN, rxIf.oRXVALID, mData, mOverrun, mValid);
        end
        errClear();
        checks++;
        if (rxIf.oOVERRUN !== mOverrun || rxIf.oRXDATA !== mData) begin
            errors++;
            $display("FAIL overrun_clear: ov=%b data=%h, want 0 %h", rxIf.oOVERRUN, rxIf.oRXDATA, mData);
        end
        readByte();
        sendFrame(8'h11, 1'b1, -1, r, cap);
        modelFrame(8'h11, 1'b1, 1'b0);
        sendFrame(8'h22, 1'b1, loadCyc, r, cap);
        modelFrame(8'h22, 1'b1, 1'b1);
        checks++;
        if (rxIf.oRXDATA !== mData || rxIf.oOVERRUN !== mOverrun || rxIf.oRXVALID !== mValid) begin
            errors++;
            $display("FAIL overrun_read_in_load: data=%h ov=%b valid=%b, want %h %b %b",
                     rxIf.oRXDATA, rxIf.oOVERRUN, rxIf.oRXVALID, mData, mOverrun, mValid);
        end
        readByte();
    endtask

    task automatic test_back_to_back();
        int r; logic [7:0] cap;
        logic [7:0] seq [3];
        logic [9:0] bits;
        seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h81;
        for (int k = 0; k < 3; k++) begin
            sendFrame(seq[k], 1'b1, loadCyc + 2, r, cap);
            checks++;
            if (cap !== seq[k] || r < 0) begin
                errors++;
                $display("FAIL b2b[%0d]: got %h (rise %0d), want %h", k, cap, r, seq[k]);
            end
        end
        mData = 8'h81; mValid = 1'b0;
        bits = {1'b1, 8'hC3, 1'b0};
        for (int i = 0; i < 4 * CPB + 8; i++) begin
            @(negedge iCLK);
            iUART_RX = bits[i / CPB];
        end
        #2 iRST = 1'b1;
        #1;
        modelReset();
        checks++;
        if (rxIf.oRXVALID !== 1'b0 || rxIf.oRXDATA !== mData || rxIf.oBUSY !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: valid=%b data=%h busy=%b, want 0 00 0",
                     rxIf.oRXVALID, rxIf.oRXDATA, rxIf.oBUSY);
        end
        iUART_RX = 1'b1;
        idleCycles(2);
        iRST = 1'b0;
        idleCycles(40);
        checks++;
        if (rxIf.oRXVALID !== 1'b0) begin
            errors++;
            $display("FAIL midframe_no_load: valid=%b, want 0", rxIf.oRXVALID);
        end
        sendFrame(8'h7E, 1'b1, -1, r, cap);
        modelFrame(8'h7E, 1'b1, 1'b0);
        checks++;
        if (rxIf.oRXDATA !== mData || rxIf.oRXVALID !== mValid || rxIf.oOVERRUN !== mOverrun) begin
            errors++;
            $display("FAIL after_reset_rx: data=%h valid=%b ov=%b, want %h 1 0",
                     rxIf.oRXDATA, rxIf.oRXVALID, rxIf.oOVERRUN, mData);
        end
    endtask

    initial begin
        rxIf.iRXREAD = 1'b0;
        rxIf.iERRCLR = 1'b0;
        modelReset();
        idleCycles(3);
        iRST = 1'b0;
        idleCycles(5);
        test_reset();
        test_single_byte();
        test_glitch();
        test_framing_error();
        test_overrun();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
